// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the multi-cycle ALU sequencer: FSM states,
// opcode map, PC source and writeback source selects.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5
    } state_t;

    localparam logic [5:0] OP_AND  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ANDI = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_LW   = 6'd5;
    localparam logic [5:0] OP_SW   = 6'd6;
    localparam logic [5:0] OP_BGT  = 6'd8;
    localparam logic [5:0] OP_BLT  = 6'd9;
    localparam logic [5:0] OP_BEQ  = 6'd10;
    localparam logic [5:0] OP_BNE  = 6'd11;
    localparam logic [5:0] OP_J    = 6'd12;
    localparam logic [5:0] OP_CALL = 6'd13;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode classifier for the sequencer; exactly one class flag
// is high for any opcode, with isIllegal covering every unmapped value.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic                isRType,
    output logic                isImm,
    output logic                isLoad,
    output logic                isStore,
    output logic                isBranch,
    output logic                isJump,
    output logic                isCall,
    output logic                isIllegal
);

    always_comb begin
        isRType   = 1'b0;
        isImm     = 1'b0;
        isLoad    = 1'b0;
        isStore   = 1'b0;
        isBranch  = 1'b0;
        isJump    = 1'b0;
        isCall    = 1'b0;
        isIllegal = 1'b0;
        case (opcode)
            OP_AND, OP_ADD, OP_SUB:         isRType  = 1'b1;
            OP_ANDI, OP_ADDI:               isImm    = 1'b1;
            OP_LW:                          isLoad   = 1'b1;
            OP_SW:                          isStore  = 1'b1;
            OP_BGT, OP_BLT, OP_BEQ, OP_BNE: isBranch = 1'b1;
            OP_J:                           isJump   = 1'b1;
            OP_CALL:                        isCall   = 1'b1;
            default:                        isIllegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for the single-ALU CPU datapath.
// Define ALU_SEQ_PERF_CNT_EN to add the cycleCount/instrCount performance counters.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] instrOpcode,
    input  logic                memReady,
    input  logic [DATA_W-1:0]   aluOut,
    output logic [OPCODE_W-1:0] aluOpcode,
    output logic                aluSrcB,
    output logic                memRead,
    output logic                memWrite,
    output logic                irWrite,
    output logic                pcWrite,
    output logic [1:0]          pcSrc,
    output logic                regWrite,
    output logic [1:0]          wbSrc,
    output logic                regDstLink,
    output logic                illegalOp,
    output logic [2:0]          state
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycleCount,
    output logic [CNT_W-1:0]    instrCount
`endif
);

    state_t              r_state;
    state_t              w_next_state;
    logic [OPCODE_W-1:0] r_opcode;
    logic                w_is_rtype;
    logic                w_is_imm;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_is_branch;
    logic                w_is_jump;
    logic                w_is_call;
    logic                w_is_illegal;
    logic                w_taken;

    alu_seq_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode    (r_opcode),
        .isRType   (w_is_rtype),
        .isImm     (w_is_imm),
        .isLoad    (w_is_load),
        .isStore   (w_is_store),
        .isBranch  (w_is_branch),
        .isJump    (w_is_jump),
        .isCall    (w_is_call),
        .isIllegal (w_is_illegal)
    );

    // Branch condition is judged purely from the ALU result, never from flags.
    always_comb begin
        w_taken = 1'b0;
        case (r_opcode)
            OP_BGT, OP_BLT: w_taken = aluOut[0];
            OP_BEQ:         w_taken = (aluOut == '0);
            OP_BNE:         w_taken = (aluOut != '0);
            default:        w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      w_next_state = FETCH;
            FETCH:     w_next_state = memReady ? DECODE : FETCH;
            DECODE:    w_next_state = w_is_illegal ? FETCH : EXECUTE;
            EXECUTE: begin
                if (w_is_rtype || w_is_imm)
                    w_next_state = WRITEBACK;
                else if (w_is_load || w_is_store)
                    w_next_state = MEM;
                else
                    w_next_state = FETCH;
            end
            MEM: begin
                if (memReady)
                    w_next_state = w_is_load ? WRITEBACK : FETCH;
            end
            WRITEBACK: w_next_state = FETCH;
            default:   w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_opcode <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == FETCH && memReady)
                r_opcode <= instrOpcode;
        end
    end

    always_comb begin
        aluOpcode  = '0;
        aluSrcB    = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        pcSrc      = PC_SEQ;
        regWrite   = 1'b0;
        wbSrc      = WB_ALU;
        regDstLink = 1'b0;
        illegalOp  = 1'b0;
        case (r_state)
            FETCH: begin
                memRead = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    pcSrc   = PC_SEQ;
                end
            end
            DECODE: illegalOp = w_is_illegal;
            EXECUTE: begin
                aluOpcode = r_opcode;
                aluSrcB   = !(w_is_rtype || w_is_branch);
                if (w_is_branch && w_taken) begin
                    pcWrite = 1'b1;
                    pcSrc   = PC_BR;
                end
                if (w_is_jump || w_is_call) begin
                    pcWrite = 1'b1;
                    pcSrc   = PC_JMP;
                end
                // The PC already points past the CALL, so it is the link value.
                if (w_is_call) begin
                    regWrite   = 1'b1;
                    wbSrc      = WB_PC;
                    regDstLink = 1'b1;
                end
            end
            MEM: begin
                aluOpcode = r_opcode;
                memRead   = w_is_load;
                memWrite  = w_is_store;
            end
            WRITEBACK: begin
                regWrite = 1'b1;
                wbSrc    = w_is_load ? WB_MEM : WB_ALU;
            end
            default: ;
        endcase
    end

    assign state = r_state;

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             w_retire;

    assign w_retire = (w_next_state == FETCH) &&
                      (r_state == DECODE || r_state == EXECUTE ||
                       r_state == MEM || r_state == WRITEBACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state != IDLE)
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_retire)
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    assign cycleCount = r_cycle_cnt;
    assign instrCount = r_instr_cnt;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: per-cycle expected control vectors are
// queued with their stimulus and compared while the clock is low.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic [5:0]  instrOpcode;
    logic        memReady;
    logic [31:0] aluOut;
    logic [5:0]  aluOpcode;
    logic        aluSrcB;
    logic        memRead;
    logic        memWrite;
    logic        irWrite;
    logic        pcWrite;
    logic [1:0]  pcSrc;
    logic        regWrite;
    logic [1:0]  wbSrc;
    logic        regDstLink;
    logic        illegalOp;
    logic [2:0]  dut_state;
`ifdef ALU_SEQ_PERF_CNT_EN
    logic [31:0] cycleCount;
    logic [31:0] instrCount;
`endif

    int checks   = 0;
    int failures = 0;

    logic [20:0] exp_q[$];
    logic [38:0] stim_q[$];
    logic [20:0] f_go, f_wait, dec, dec_ill;

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instrOpcode (instrOpcode),
        .memReady    (memReady),
        .aluOut      (aluOut),
        .aluOpcode   (aluOpcode),
        .aluSrcB     (aluSrcB),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .pcWrite     (pcWrite),
        .pcSrc       (pcSrc),
        .regWrite    (regWrite),
        .wbSrc       (wbSrc),
        .regDstLink  (regDstLink),
        .illegalOp   (illegalOp),
        .state       (dut_state)
`ifdef ALU_SEQ_PERF_CNT_EN
        ,
        .cycleCount  (cycleCount),
        .instrCount  (instrCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Expected vector layout: state, aluOpcode, aluSrcB, memRead, memWrite,
    // irWrite, pcWrite, pcSrc, regWrite, wbSrc, regDstLink, illegalOp.
    function automatic logic [20:0] v(input logic [2:0] st, input logic [5:0] aop,
                                      input logic srcb, input logic mr, input logic mw,
                                      input logic ir, input logic pcw, input logic [1:0] pcs,
                                      input logic rw, input logic [1:0] wb,
                                      input logic lnk, input logic ill);
        return {st, aop, srcb, mr, mw, ir, pcw, pcs, rw, wb, lnk, ill};
    endfunction

    function automatic logic [20:0] got_vec();
        return {dut_state, aluOpcode, aluSrcB, memRead, memWrite, irWrite, pcWrite,
                pcSrc, regWrite, wbSrc, regDstLink, illegalOp};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] ro();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic push_cyc(input logic mr, input logic [5:0] op, input logic [31:0] alu,
                            input logic [20:0] e);
        stim_q.push_back({mr, op, alu});
        exp_q.push_back(e);
    endtask

    task automatic drive_next();
        logic [38:0] s;
        s = stim_q.pop_front();
        @(negedge clk);
        memReady    = s[38];
        instrOpcode = s[37:32];
        aluOut      = s[31:0];
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        memReady = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        memReady    = 1'b1;
        instrOpcode = 6'd1;
        aluOut      = '0;
        @(negedge clk);
        #1;
        checks++;
        if (got_vec() !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", got_vec(), 21'd0);
        end
        rst_n    = 1'b1;
        memReady = 1'b0;
        #1;
        checks++;
        if (dut_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_release_idle got=%0d exp=0", dut_state);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut_state !== 3'd1) begin
            failures++;
            $display("FAIL reset_to_fetch got=%0d exp=1", dut_state);
        end
    endtask

    task automatic test_call();
        int n = 0;
        logic [20:0] e;
        do_reset();
        push_cyc(1'b1, 6'd13, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec);
        push_cyc(rb(), ro(), $urandom, v(3, 13, 1, 0, 0, 0, 1, 2, 1, 2, 1, 0));
        push_cyc(1'b0, ro(), $urandom, f_wait);
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== e) begin
                failures++;
                $display("FAIL call cyc=%0d got=%h exp=%h", n, got_vec(), e);
            end
            n++;
        end
`ifdef ALU_SEQ_PERF_CNT_EN
        checks++;
        if (instrCount !== 32'd1) begin
            failures++;
            $display("FAIL call_instr_count got=%0d exp=1", instrCount);
        end
        checks++;
        if (cycleCount !== 32'd3) begin
            failures++;
            $display("FAIL call_cycle_count got=%0d exp=3", cycleCount);
        end
`endif
    endtask

    task automatic test_add();
        int n = 0;
        logic [20:0] e;
        push_cyc(1'b1, 6'd1, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec);
        push_cyc(rb(), ro(), $urandom, v(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_cyc(rb(), ro(), $urandom, v(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        push_cyc(1'b0, ro(), $urandom, f_wait);
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== e) begin
                failures++;
                $display("FAIL add cyc=%0d got=%h exp=%h", n, got_vec(), e);
            end
            n++;
        end
    endtask

    task automatic test_lw_wait();
        int n = 0;
        logic [20:0] e;
        push_cyc(1'b1, 6'd5, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec);
        push_cyc(rb(), ro(), $urandom, v(3, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            push_cyc(1'b0, ro(), $urandom, v(4, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        push_cyc(1'b1, ro(), $urandom, v(4, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        push_cyc(rb(), ro(), $urandom, v(5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        push_cyc(1'b0, ro(), $urandom, f_wait);
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== e) begin
                failures++;
                $display("FAIL lw_wait cyc=%0d got=%h exp=%h", n, got_vec(), e);
            end
            n++;
        end
    endtask

    task automatic test_branch();
        int n = 0;
        logic [20:0] e;
        push_cyc(1'b1, 6'd10, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec);
        push_cyc(rb(), ro(), 32'd0, v(3, 10, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        push_cyc(1'b1, 6'd11, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec);
        push_cyc(rb(), ro(), 32'd0, v(3, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_cyc(1'b1, 6'd8, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec);
        push_cyc(rb(), ro(), 32'd5, v(3, 8, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        push_cyc(1'b1, 6'd9, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec);
        push_cyc(rb(), ro(), 32'd6, v(3, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_cyc(1'b0, ro(), $urandom, f_wait);
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== e) begin
                failures++;
                $display("FAIL branch cyc=%0d got=%h exp=%h", n, got_vec(), e);
            end
            n++;
        end
    endtask

    task automatic test_jump_imm_sw();
        int n = 0;
        logic [20:0] e;
        push_cyc(1'b1, 6'd12, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec);
        push_cyc(rb(), ro(), $urandom, v(3, 12, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        push_cyc(1'b1, 6'd4, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec);
        push_cyc(rb(), ro(), $urandom, v(3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_cyc(rb(), ro(), $urandom, v(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        push_cyc(1'b1, 6'd6, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec);
        push_cyc(rb(), ro(), $urandom, v(3, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_cyc(1'b1, ro(), $urandom, v(4, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push_cyc(1'b0, ro(), $urandom, f_wait);
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== e) begin
                failures++;
                $display("FAIL jump_imm_sw cyc=%0d got=%h exp=%h", n, got_vec(), e);
            end
            n++;
        end
    endtask

    task automatic test_illegal();
        int n = 0;
        logic [20:0] e;
        push_cyc(1'b1, 6'd7, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec_ill);
        push_cyc(1'b1, 6'd20, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec_ill);
        push_cyc(1'b0, ro(), $urandom, f_wait);
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== e) begin
                failures++;
                $display("FAIL illegal cyc=%0d got=%h exp=%h", n, got_vec(), e);
            end
            n++;
        end
    endtask

    task automatic test_sw_reset();
        int n = 0;
        logic [20:0] e;
        push_cyc(1'b1, 6'd6, $urandom, f_go);
        push_cyc(rb(), ro(), $urandom, dec);
        push_cyc(rb(), ro(), $urandom, v(3, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_cyc(1'b0, ro(), $urandom, v(4, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        while (exp_q.size() != 0) begin
            drive_next();
            e = exp_q.pop_front();
            checks++;
            if (got_vec() !== e) begin
                failures++;
                $display("FAIL sw_reset cyc=%0d got=%h exp=%h", n, got_vec(), e);
            end
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (memWrite !== 1'b0) begin
            failures++;
            $display("FAIL sw_reset_memwrite got=%b exp=0", memWrite);
        end
        checks++;
        if (dut_state !== 3'd0) begin
            failures++;
            $display("FAIL sw_reset_state got=%0d exp=0", dut_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (dut_state !== 3'd0) begin
            failures++;
            $display("FAIL sw_reset_idle got=%0d exp=0", dut_state);
        end
        @(negedge clk);
        #1;
        checks++;
        if (got_vec() !== f_wait) begin
            failures++;
            $display("FAIL sw_reset_fetch got=%h exp=%h", got_vec(), f_wait);
        end
    endtask

    initial begin
        f_go    = v(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        f_wait  = v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        dec     = v(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dec_ill = v(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        test_reset();
        test_call();
        test_add();
        test_lw_wait();
        test_branch();
        test_jump_imm_sw();
        test_illegal();
        test_sw_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
